cpld_disp_arbiter: RTL and testbench

Shares the single CPLD display/switch front-end (cpld_if) between N_REQ client blocks. It performs round-robin arbitration with a max-hold preemption timer and a one-cycle blanking gap between owners. It drives the registered LED/digit inputs of cpld_if from the current owner. It debounces the switch word returned by cpld_if and routes change events only to the owner.

---
 rtl/cpld_disp_pkg.sv | 38 +++
 rtl/sw_debounce.sv | 41 ++++
 rtl/cpld_disp_arbiter.sv | 149 ++++++++++++++
 tb/tb_cpld_disp_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpld_disp_pkg.sv
// cpld_disp_pkg: shared types and helpers for the CPLD display arbiter.
//   state_t  - arbiter FSM state (IDLE / OWN / GAP)
//   rr_next  - round-robin search: first set req bit after ptr, modulo n
package cpld_disp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   // Requester vectors are carried at this fixed width internally so that
   // the search helper does not need to be parameterised.
   localparam int unsigned MAX_REQ = 8;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } rr_pick_t;

   // Searches ptr+1, ptr+2, ... ptr+n (mod n); ptr itself is tried last.
   function automatic rr_pick_t rr_next(input logic [MAX_REQ-1:0] req,
                                        input logic [2:0]         ptr,
                                        input int unsigned        n);
      rr_pick_t    pick;
      int unsigned cand;
      pick = '0;
      for (int unsigned i = 1; i <= n; i++) begin
         cand = (32'(ptr) + i) % n;
         if (!pick.found && req[cand[2:0]]) begin
            pick.found = 1'b1;
            pick.idx   = cand[2:0];
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: per-word debouncer for the switch bus returned by cpld_if.
//   clk, rst  - clock, synchronous active-high reset
//   din       - raw switch word
//   dout      - accepted (debounced) switch word
//   chg       - combinational strobe, high during the cycle whose closing
//               edge loads a new value into dout
module sw_debounce
   import cpld_disp_pkg::*;
#(
   parameter int unsigned W          = 8,
   parameter logic [15:0] DEB_CYCLES = 16'd4096
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         chg
);

   logic [W-1:0] cand;
   logic [15:0]  cnt;

   // Exposed combinationally so the parent can register its event on the
   // same edge that updates dout.
   assign chg = (din == cand) && (cnt == DEB_CYCLES - 16'd1) && (cand != dout);

   always_ff @(posedge clk) begin
      if (rst) begin
         cand <= '0;
         cnt  <= '0;
         dout <= '0;
      end else if (din != cand) begin
         cand <= din;
         cnt  <= '0;
      end else begin
         if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
         if (chg) dout <= cand;
      end
   end

endmodule

// File: rtl/cpld_disp_arbiter.sv
// cpld_disp_arbiter: shares the cpld_if display/switch front-end among
// N_REQ clients with round-robin arbitration, max-hold preemption and a
// one-cycle blanking gap between owners.
//   clk, rst           - clock, synchronous active-high reset
//   req                - per-client level request
//   led_in/dig0_in/dig1_in - packed client display words (client i at slice i)
//   gnt                - registered one-hot grant
//   led/dig0/dig1      - registered display words to cpld_if
//   sw_raw             - switch word from cpld_if
//   sw                 - debounced switch word (broadcast)
//   sw_evt             - one-cycle change pulse to the owner only
//   busy               - any grant active
module cpld_disp_arbiter
   import cpld_disp_pkg::*;
#(
   parameter int unsigned N_REQ      = 4,
   parameter logic [15:0] MAX_HOLD   = 16'd50000,
   parameter logic [15:0] DEB_CYCLES = 16'd4096,
   parameter logic [7:0]  IDLE_LED   = 8'h00
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req,
   input  logic [8*N_REQ-1:0]   led_in,
   input  logic [4*N_REQ-1:0]   dig0_in,
   input  logic [4*N_REQ-1:0]   dig1_in,
   output logic [N_REQ-1:0]     gnt,
   output logic [7:0]           led,
   output logic [3:0]           dig0,
   output logic [3:0]           dig1,
   input  logic [7:0]           sw_raw,
   output logic [7:0]           sw,
   output logic [N_REQ-1:0]     sw_evt,
   output logic                 busy
);

   state_t             state;
   logic [2:0]         ptr;
   logic [15:0]        hold_cnt;

   logic [MAX_REQ-1:0] req_w;
   rr_pick_t           pick;
   logic [N_REQ-1:0]   pick_oh;
   logic               owner_req;
   logic               others_req;
   logic               deb_chg;

   logic [7:0]         led_a  [MAX_REQ];
   logic [3:0]         dig0_a [MAX_REQ];
   logic [3:0]         dig1_a [MAX_REQ];

   // Unpack client words into fixed-size arrays (unused slots read as zero)
   // so a 3-bit index selects them without width games.
   always_comb begin
      for (int unsigned i = 0; i < MAX_REQ; i++) begin
         led_a[i]  = '0;
         dig0_a[i] = '0;
         dig1_a[i] = '0;
      end
      for (int unsigned i = 0; i < N_REQ; i++) begin
         led_a[i]  = led_in[8*i +: 8];
         dig0_a[i] = dig0_in[4*i +: 4];
         dig1_a[i] = dig1_in[4*i +: 4];
      end
   end

   always_comb begin
      req_w              = '0;
      req_w[N_REQ-1:0]   = req;
      pick               = rr_next(req_w, ptr, N_REQ);
      pick_oh            = '0;
      for (int unsigned i = 0; i < N_REQ; i++)
         pick_oh[i] = pick.found && (pick.idx == 3'(i));
      owner_req          = req_w[ptr];
      others_req         = |(req & ~gnt);
   end

   sw_debounce #(
      .W          (8),
      .DEB_CYCLES (DEB_CYCLES)
   ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .din  (sw_raw),
      .dout (sw),
      .chg  (deb_chg)
   );

   assign busy = |gnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         gnt      <= '0;
         led      <= IDLE_LED;
         dig0     <= '0;
         dig1     <= '0;
         sw_evt   <= '0;
         ptr      <= 3'(N_REQ - 1);
         hold_cnt <= '0;
      end else begin
         // Change events go only to whoever owned the display on the
         // accepting edge; with no owner the event is dropped.
         sw_evt <= deb_chg ? gnt : '0;

         case (state)
            ST_IDLE, ST_GAP: begin
               if (pick.found) begin
                  state    <= ST_OWN;
                  gnt      <= pick_oh;
                  ptr      <= pick.idx;
                  hold_cnt <= '0;
                  led      <= led_a[pick.idx];
                  dig0     <= dig0_a[pick.idx];
                  dig1     <= dig1_a[pick.idx];
               end else begin
                  state <= ST_IDLE;
                  gnt   <= '0;
                  led   <= IDLE_LED;
                  dig0  <= '0;
                  dig1  <= '0;
               end
            end
            ST_OWN: begin
               if (hold_cnt != MAX_HOLD) hold_cnt <= hold_cnt + 16'd1;
               if (!owner_req || (hold_cnt == MAX_HOLD && others_req)) begin
                  state <= ST_GAP;
                  gnt   <= '0;
                  led   <= IDLE_LED;
                  dig0  <= '0;
                  dig1  <= '0;
               end else begin
                  led  <= led_a[ptr];
                  dig0 <= dig0_a[ptr];
                  dig1 <= dig1_a[ptr];
               end
            end
            default: begin
               state <= ST_IDLE;
               gnt   <= '0;
               led   <= IDLE_LED;
               dig0  <= '0;
               dig1  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpld_disp_arbiter.sv
// tb_cpld_disp_arbiter: directed scoreboard bench for cpld_disp_arbiter
// (N_REQ=4, MAX_HOLD=8, DEB_CYCLES=16).
module tb_cpld_disp_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] led_in;
   logic [15:0] dig0_in;
   logic [15:0] dig1_in;
   logic [3:0]  gnt;
   logic [7:0]  led;
   logic [3:0]  dig0;
   logic [3:0]  dig1;
   logic [7:0]  sw_raw;
   logic [7:0]  sw;
   logic [3:0]  sw_evt;
   logic        busy;

   always #5 clk = ~clk;

   cpld_disp_arbiter #(
      .N_REQ      (4),
      .MAX_HOLD   (16'd8),
      .DEB_CYCLES (16'd16),
      .IDLE_LED   (8'h00)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .led_in  (led_in),
      .dig0_in (dig0_in),
      .dig1_in (dig1_in),
      .gnt     (gnt),
      .led     (led),
      .dig0    (dig0),
      .dig1    (dig1),
      .sw_raw  (sw_raw),
      .sw      (sw),
      .sw_evt  (sw_evt),
      .busy    (busy)
   );

   typedef enum {K_GNT, K_LED, K_DIG0, K_DIG1, K_SW, K_EVT, K_BUSY} kind_e;
   typedef struct {
      string      tag;
      kind_e      kind;
      logic [7:0] val;
   } exp_t;

   exp_t        sbq[$];
   int unsigned n_total = 0;
   int unsigned n_pass  = 0;
   int unsigned n_fail  = 0;

   task automatic expect_val(input string tag, input kind_e k, input logic [7:0] v);
      exp_t e;
      e.tag  = tag;
      e.kind = k;
      e.val  = v;
      sbq.push_back(e);
   endtask

   // Advance one clock, then compare every expectation queued for this cycle.
   task automatic step();
      exp_t       e;
      logic [7:0] obs;
      @(posedge clk);
      #1;
      while (sbq.size() != 0) begin
         e   = sbq.pop_front();
         obs = '0;
         case (e.kind)
            K_GNT:  obs = {4'b0, gnt};
            K_LED:  obs = led;
            K_DIG0: obs = {4'b0, dig0};
            K_DIG1: obs = {4'b0, dig1};
            K_SW:   obs = sw;
            K_EVT:  obs = {4'b0, sw_evt};
            K_BUSY: obs = {7'b0, busy};
            default: obs = 'x;
         endcase
         n_total++;
         assert (obs === e.val) n_pass++;
         else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic do_reset(input string tag);
      rst    = 1'b1;
      req    = '0;
      sw_raw = '0;
      expect_val({tag, "_gnt"},  K_GNT,  8'h00);
      expect_val({tag, "_led"},  K_LED,  8'h00);
      expect_val({tag, "_sw"},   K_SW,   8'h00);
      expect_val({tag, "_evt"},  K_EVT,  8'h00);
      expect_val({tag, "_busy"}, K_BUSY, 8'h00);
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst     = 1'b1;
      req     = '0;
      led_in  = '0;
      dig0_in = '0;
      dig1_in = '0;
      sw_raw  = '0;
      @(posedge clk);
      #1;

      // 1: idle with no requests; client inputs non-zero so a leak shows.
      do_reset("s1_rst");
      led_in  = 32'h11223344;
      dig0_in = 16'h1234;
      dig1_in = 16'h5678;
      for (int k = 1; k <= 20; k++) begin
         expect_val($sformatf("s1_gnt_c%0d", k),  K_GNT,  8'h00);
         expect_val($sformatf("s1_busy_c%0d", k), K_BUSY, 8'h00);
         expect_val($sformatf("s1_led_c%0d", k),  K_LED,  8'h00);
         expect_val($sformatf("s1_dig0_c%0d", k), K_DIG0, 8'h00);
         expect_val($sformatf("s1_dig1_c%0d", k), K_DIG1, 8'h00);
         step();
      end

      // 2: grant, display pass-through, release and handover to client 2.
      // Release happens at cycle 5 so MAX_HOLD=8 preemption cannot interfere.
      do_reset("s2_rst");
      led_in  = 32'h005C_00A5;
      dig0_in = 16'h0903;
      dig1_in = 16'h060C;
      req     = 4'b0101;
      expect_val("s2_gnt_c1",  K_GNT,  8'h01);
      expect_val("s2_busy_c1", K_BUSY, 8'h01);
      step();
      expect_val("s2_led_c2",  K_LED,  8'hA5);
      expect_val("s2_dig0_c2", K_DIG0, 8'h03);
      expect_val("s2_dig1_c2", K_DIG1, 8'h0C);
      step();
      for (int k = 3; k <= 5; k++) begin
         expect_val($sformatf("s2_gnt_c%0d", k), K_GNT, 8'h01);
         step();
      end
      req = 4'b0100;
      expect_val("s2_gap_gnt",  K_GNT,  8'h00);
      expect_val("s2_gap_led",  K_LED,  8'h00);
      expect_val("s2_gap_dig0", K_DIG0, 8'h00);
      expect_val("s2_gap_busy", K_BUSY, 8'h00);
      step();
      expect_val("s2_hand_gnt", K_GNT, 8'h04);
      step();
      expect_val("s2_hand_led",  K_LED,  8'h5C);
      expect_val("s2_hand_dig0", K_DIG0, 8'h09);
      expect_val("s2_hand_dig1", K_DIG1, 8'h06);
      step();

      // 3: two competitors, MAX_HOLD=8 -> 9-cycle ownership, 1-cycle gap.
      do_reset("s3_rst");
      req = 4'b0011;
      for (int k = 1; k <= 40; k++) begin
         int unsigned p;
         logic [7:0]  eg;
         p = (k - 1) % 10;
         if (p == 9) eg = 8'h00;
         else        eg = (((k - 1) / 10) % 2 == 0) ? 8'h01 : 8'h02;
         expect_val($sformatf("s3_gnt_c%0d", k), K_GNT, eg);
         step();
      end

      // 4: lone requester is never preempted.
      do_reset("s4_rst");
      req = 4'b1000;
      for (int k = 1; k <= 1000; k++) begin
         expect_val($sformatf("s4_gnt_c%0d", k), K_GNT, 8'h08);
         step();
      end

      // 5: debounce with client 2 as owner.
      do_reset("s5_rst");
      req = 4'b0100;
      expect_val("s5_gnt", K_GNT, 8'h04);
      step();
      for (int j = 0; j < 20; j++) begin
         sw_raw = (j % 2 == 0) ? 8'h01 : 8'h00;
         for (int k = 0; k < 5; k++) begin
            expect_val($sformatf("s5_bounce_sw_%0d_%0d", j, k),  K_SW,  8'h00);
            expect_val($sformatf("s5_bounce_evt_%0d_%0d", j, k), K_EVT, 8'h00);
            step();
         end
      end
      sw_raw = 8'h01;
      for (int k = 1; k <= 16; k++) begin
         expect_val($sformatf("s5_settle_sw_c%0d", k),  K_SW,  8'h00);
         expect_val($sformatf("s5_settle_evt_c%0d", k), K_EVT, 8'h00);
         step();
      end
      expect_val("s5_accept_sw",  K_SW,  8'h01);
      expect_val("s5_accept_evt", K_EVT, 8'h04);
      step();
      expect_val("s5_after_sw",  K_SW,  8'h01);
      expect_val("s5_after_evt", K_EVT, 8'h00);
      step();

      // 6: reset in the middle of an ownership.
      do_reset("s6_rst");
      led_in = 32'h0000_5A00;
      req    = 4'b0010;
      sw_raw = 8'h3C;
      expect_val("s6_gnt", K_GNT, 8'h02);
      step();
      for (int k = 2; k <= 17; k++) step();
      expect_val("s6_pre_sw",  K_SW,  8'h3C);
      expect_val("s6_pre_led", K_LED, 8'h5A);
      expect_val("s6_pre_gnt", K_GNT, 8'h02);
      step();
      rst = 1'b1;
      expect_val("s6_mid_gnt",  K_GNT,  8'h00);
      expect_val("s6_mid_sw",   K_SW,   8'h00);
      expect_val("s6_mid_led",  K_LED,  8'h00);
      expect_val("s6_mid_busy", K_BUSY, 8'h00);
      expect_val("s6_mid_evt",  K_EVT,  8'h00);
      step();
      rst = 1'b0;
      req = 4'b1111;
      expect_val("s6_first_gnt", K_GNT, 8'h01);
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
